// File: rtl/gate_sequencer_pkg.sv
// gate_sequencer_pkg
//   Shared definitions for the lane gate sequencer and the parking FSM it talks to:
//   slot count and slot-index width, sequencer state encoding, lane encoding,
//   capacity encoding, and helpers used to size the saturating counters.
package gate_sequencer_pkg;

  localparam int PMS_SLOTS = 4;
  localparam int SLOT_W    = $clog2(PMS_SLOTS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_OPEN     = 3'd3,
    ST_REJECT   = 3'd4
  } gs_state_t;

  typedef enum logic {
    LANE_ENTRY = 1'b0,
    LANE_EXIT  = 1'b1
  } lane_t;

  typedef enum logic [1:0] {
    CAP_EMPTY   = 2'd0,
    CAP_PARTIAL = 2'd1,
    CAP_FULL    = 2'd2
  } capacity_t;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gate_sequencer_debounce.sv
// gate_sequencer_debounce
//   Two-flop synchroniser followed by a stability counter. The debounced level only
//   changes after DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
// Ports
//   clk     in  clock
//   reset   in  synchronous, active-low reset
//   sensor  in  raw asynchronous sensor
//   level   out debounced level
//   rise    out one-cycle strobe, high in the cycle where level is about to go 0->1
module gate_sequencer_debounce
  import gate_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  output logic level,
  output logic rise
);

  localparam int              CW  = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   LIM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          accept;

  assign accept = (sync_q[1] != level) && (cnt_q == LIM);
  assign rise   = accept && sync_q[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sensor};
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (accept) begin
        level <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gate_sequencer.sv
// gate_sequencer
//   Request side of the parking handshake. Debounces the entry/exit car sensors,
//   validates each request against the FSM's spots/is_full, issues one-cycle
//   entry_signal/exit_signal pulses, waits for is_open, then holds the barrier up
//   until the car has cleared the lane.
//   Build option GATE_RR_ARB_EN: simultaneous entry+exit requests are served
//   round-robin; without it the exit lane always wins a tie.
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   entry_sensor, exit_sensor  raw car-present sensors
//   exit_slot_sel              slot keyed in by exiting driver, captured on exit edge
//   is_open, is_full, spots    acknowledge / full flag / occupancy map from the FSM
//   entry_signal, exit_signal  one-cycle requests to the FSM
//   exit_slot                  slot to free, valid in REQ and WAIT_ACK
//   gate_up                    barrier raise command
//   full_lamp                  entry rejected for lack of space (one cycle)
//   busy                       not IDLE
//   err                        one-cycle pulse on reject, ack timeout, pass timeout
//
//   state    | meaning
//   IDLE     | waiting for a pending lane; selects, validates
//   REQ      | one-cycle request pulse to the FSM
//   WAIT_ACK | waiting for is_open, bounded by ACK_TIMEOUT
//   OPEN     | barrier up until hold time met and lane clear, bounded by PASS_TIMEOUT
//   REJECT   | one-cycle err (and full_lamp for entry)
module gate_sequencer
  import gate_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OPEN_CYCLES     = 1000,
  parameter int ACK_TIMEOUT     = 4,
  parameter int PASS_TIMEOUT    = 5000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_sensor,
  input  logic                 exit_sensor,
  input  logic [SLOT_W-1:0]    exit_slot_sel,
  input  logic                 is_open,
  input  logic                 is_full,
  input  logic [PMS_SLOTS-1:0] spots,
  output logic                 entry_signal,
  output logic                 exit_signal,
  output logic [SLOT_W-1:0]    exit_slot,
  output logic                 gate_up,
  output logic                 full_lamp,
  output logic                 busy,
  output logic                 err
);

  localparam int            TW       = cnt_width(max3(ACK_TIMEOUT, OPEN_CYCLES, PASS_TIMEOUT));
  localparam logic [TW-1:0] ACK_LIM  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] OPEN_LIM = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] PASS_LIM = TW'(PASS_TIMEOUT - 1);

  gs_state_t           state_q, state_nxt;
  lane_t               lane_q;
  logic                entry_level, entry_rise, exit_level, exit_rise;
  logic                pend_entry_q, pend_exit_q;
  logic [SLOT_W-1:0]   slot_q, slot_act_q;
  logic [TW-1:0]       timer_q;
  logic                in_idle, pick_any, pick_exit, exit_wins_tie, req_ok;
  logic                lane_level, open_done;

  gate_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
    .clk    (clk),
    .reset  (reset),
    .sensor (entry_sensor),
    .level  (entry_level),
    .rise   (entry_rise)
  );

  gate_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
    .clk    (clk),
    .reset  (reset),
    .sensor (exit_sensor),
    .level  (exit_level),
    .rise   (exit_rise)
  );

  assign in_idle   = (state_q == ST_IDLE);
  assign pick_any  = pend_entry_q | pend_exit_q;
  assign pick_exit = pend_exit_q & (~pend_entry_q | exit_wins_tie);
  assign req_ok    = pick_exit ? spots[slot_q] : ~(is_full | (&spots));

  assign lane_level = (lane_q == LANE_EXIT) ? exit_level : entry_level;
  assign open_done  = (timer_q >= OPEN_LIM) && !lane_level;

`ifdef GATE_RR_ARB_EN
  // Pointer only moves when a real tie was arbitrated, so a lone request in
  // between does not steal the other lane's turn.
  logic last_exit_q;

  assign exit_wins_tie = ~last_exit_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_exit_q <= 1'b0;
    end else if (in_idle && pend_entry_q && pend_exit_q) begin
      last_exit_q <= pick_exit;
    end
  end
`else
  assign exit_wins_tie = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:     if (pick_any) state_nxt = req_ok ? ST_REQ : ST_REJECT;
      ST_REQ:      state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (is_open)                  state_nxt = ST_OPEN;
        else if (timer_q == ACK_LIM)  state_nxt = ST_IDLE;
      end
      ST_OPEN: begin
        if (open_done || (timer_q == PASS_LIM)) state_nxt = ST_IDLE;
      end
      ST_REJECT:   state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    entry_signal = 1'b0;
    exit_signal  = 1'b0;
    exit_slot    = '0;
    gate_up      = 1'b0;
    full_lamp    = 1'b0;
    err          = 1'b0;
    busy         = !in_idle;
    case (state_q)
      ST_REQ: begin
        entry_signal = (lane_q == LANE_ENTRY);
        exit_signal  = (lane_q == LANE_EXIT);
        exit_slot    = (lane_q == LANE_EXIT) ? slot_act_q : '0;
      end
      ST_WAIT_ACK: begin
        exit_slot = (lane_q == LANE_EXIT) ? slot_act_q : '0;
        err       = !is_open && (timer_q == ACK_LIM);
      end
      ST_OPEN: begin
        // Forced close drops the barrier in the same cycle the error is flagged.
        err     = !open_done && (timer_q == PASS_LIM);
        gate_up = !err;
      end
      ST_REJECT: begin
        err       = 1'b1;
        full_lamp = (lane_q == LANE_ENTRY);
      end
      default: ;
    endcase
  end

  // Pending flags, captured slot, active lane and the shared state timer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_entry_q <= 1'b0;
      pend_exit_q  <= 1'b0;
      slot_q       <= '0;
      slot_act_q   <= '0;
      lane_q       <= LANE_ENTRY;
      timer_q      <= '0;
    end else begin
      pend_entry_q <= (pend_entry_q | entry_rise) & ~(in_idle & pick_any & ~pick_exit);
      pend_exit_q  <= (pend_exit_q | exit_rise) & ~(in_idle & pick_exit);
      if (exit_rise && !pend_exit_q) slot_q <= exit_slot_sel;
      if (in_idle && pick_any) begin
        lane_q     <= pick_exit ? LANE_EXIT : LANE_ENTRY;
        slot_act_q <= slot_q;
      end
      if (state_nxt != state_q) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gate_sequencer.sv
`timescale 1ns/1ps
module tb_gate_sequencer;

  localparam int DEB  = 2;
  localparam int OPN  = 4;
  localparam int ACK  = 3;
  localparam int PASS = 20;

  localparam int EV_ENTRY     = 100;
  localparam int EV_EXIT      = 200;
  localparam int EV_REJ_ENTRY = 300;
  localparam int EV_ERR       = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entry_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic [1:0] exit_slot_sel = 2'd0;
  logic       is_open = 1'b0;
  logic       is_full = 1'b0;
  logic [3:0] spots = 4'd0;
  logic       entry_signal, exit_signal, gate_up, full_lamp, busy, err;
  logic [1:0] exit_slot;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc = 0, n_entry = 0, n_exit = 0, n_both = 0, n_gate = 0, n_lamp = 0;
  int last_req_cyc = 0, last_err_cyc = 0;
  int ev_q[$];
  int exp_q[$];
  bit ack_en = 1'b1;
`ifdef GATE_RR_ARB_EN
  bit rr_last_exit = 1'b0;
`endif

  always #5 clk = ~clk;

  gate_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .OPEN_CYCLES     (OPN),
    .ACK_TIMEOUT     (ACK),
    .PASS_TIMEOUT    (PASS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .entry_sensor  (entry_sensor),
    .exit_sensor   (exit_sensor),
    .exit_slot_sel (exit_slot_sel),
    .is_open       (is_open),
    .is_full       (is_full),
    .spots         (spots),
    .entry_signal  (entry_signal),
    .exit_signal   (exit_signal),
    .exit_slot     (exit_slot),
    .gate_up       (gate_up),
    .full_lamp     (full_lamp),
    .busy          (busy),
    .err           (err)
  );

  // Event log of everything the sequencer tells the outside world.
  always @(negedge clk) begin
    cyc++;
    if (entry_signal) begin n_entry++; ev_q.push_back(EV_ENTRY); last_req_cyc = cyc; end
    if (exit_signal) begin n_exit++; ev_q.push_back(EV_EXIT + int'(exit_slot)); last_req_cyc = cyc; end
    if (entry_signal && exit_signal) n_both++;
    if (err) begin ev_q.push_back(full_lamp ? EV_REJ_ENTRY : EV_ERR); last_err_cyc = cyc; end
    if (full_lamp) n_lamp++;
    if (gate_up) n_gate++;
  end

  // Parking FSM stand-in: acknowledges a request during the following cycle.
  always begin
    @(negedge clk);
    if (ack_en && (entry_signal || exit_signal)) begin
      @(posedge clk); #2; is_open = 1'b1;
      @(posedge clk); #2; is_open = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input bit en, input bit ex, input logic [1:0] slot, input int hold);
    tick(1);
    exit_slot_sel = slot;
    if (en) entry_sensor = 1'b1;
    if (ex) exit_sensor = 1'b1;
    tick(hold);
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
  endtask

  task automatic wait_quiet(output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) quiet = 0; else quiet++;
      if (quiet >= 8) begin ok = 1'b1; break; end
    end
  endtask

  // Outcome-level reference: which requests go out, in which order, and how each ends.
  task automatic model_predict(input bit do_en, input bit do_ex, input logic [3:0] sp,
                               input bit full, input logic [1:0] slot);
    bit ex_first = 1'b1;
    int ex_ev, en_ev;
    exp_q.delete();
    ex_ev = sp[slot] ? EV_EXIT + int'(slot) : EV_ERR;
    en_ev = (full || sp == 4'hF) ? EV_REJ_ENTRY : EV_ENTRY;
`ifdef GATE_RR_ARB_EN
    if (do_en && do_ex) begin
      ex_first = !rr_last_exit;
      rr_last_exit = ex_first;
    end
`endif
    if (do_ex && ex_first) exp_q.push_back(ex_ev);
    if (do_en) exp_q.push_back(en_ev);
    if (do_ex && !ex_first) exp_q.push_back(ex_ev);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    @(negedge clk);
    n_assert++;
    if ({entry_signal, exit_signal, exit_slot, gate_up, full_lamp, busy, err} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {entry_signal, exit_signal, exit_slot, gate_up, full_lamp, busy, err});
    end
    reset = 1'b1;
    tick(3);
  endtask

  task automatic test_entry_basic();
    int start = ev_q.size(), g0 = n_gate, e0 = n_entry;
    bit found = 1'b0, ok;
    spots = 4'b0000; is_full = 1'b0;
    tick(1);
    entry_sensor = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gate_up) begin found = 1'b1; break; end
    end
    n_assert++;
    if (!found) begin n_fail++; $display("FAIL basic_gate_rise: gate_up got 0, required 1 within 40 cycles"); end
    tick(8);
    @(negedge clk);
    n_assert++;
    if (gate_up !== 1'b1) begin n_fail++; $display("FAIL basic_gate_hold_car_present: gate_up got %b, required 1", gate_up); end
    tick(1);
    entry_sensor = 1'b0;
    wait_quiet(ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL basic_idle: busy got 1, required 0 within 300 cycles"); end
    n_assert++;
    if (gate_up !== 1'b0) begin n_fail++; $display("FAIL basic_gate_drop: gate_up got %b, required 0", gate_up); end
    n_assert++;
    if (n_entry - e0 != 1) begin n_fail++; $display("FAIL basic_pulse_count: got %0d entry pulses, required 1", n_entry - e0); end
    n_assert++;
    if (n_gate - g0 < OPN) begin n_fail++; $display("FAIL basic_gate_cycles: got %0d, required >= %0d", n_gate - g0, OPN); end
    n_assert++;
    if (ev_q.size() - start != 1 || ev_q[start] != EV_ENTRY) begin
      n_fail++; $display("FAIL basic_events: got %0d events, required exactly one entry request", ev_q.size() - start);
    end
  endtask

  task automatic test_full_reject();
    int start = ev_q.size(), e0 = n_entry, l0 = n_lamp, g0 = n_gate;
    bit ok;
    spots = 4'b1111; is_full = 1'b1;
    press(1'b1, 1'b0, 2'd0, 5);
    wait_quiet(ok);
    model_predict(1'b1, 1'b0, spots, is_full, 2'd0);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL full_idle: busy got 1, required 0"); end
    n_assert++;
    if (n_entry - e0 != 0) begin n_fail++; $display("FAIL full_no_request: got %0d entry pulses, required 0", n_entry - e0); end
    n_assert++;
    if (n_lamp - l0 != 1) begin n_fail++; $display("FAIL full_lamp_cycles: got %0d, required 1", n_lamp - l0); end
    n_assert++;
    if (n_gate - g0 != 0) begin n_fail++; $display("FAIL full_gate: got %0d gate cycles, required 0", n_gate - g0); end
    n_assert++;
    if (ev_q.size() - start != exp_q.size()) begin
      n_fail++; $display("FAIL full_ev_count: got %0d, required %0d", ev_q.size() - start, exp_q.size());
    end else foreach (exp_q[i]) begin
      n_assert++;
      if (ev_q[start + i] != exp_q[i]) begin n_fail++; $display("FAIL full_ev[%0d]: got %0d, required %0d", i, ev_q[start + i], exp_q[i]); end
    end
    is_full = 1'b0;
  endtask

  task automatic test_exit_slot();
    int start, x0, l0;
    bit ok;
    spots = 4'b0100; is_full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic [1:0] sel;
      sel = (k == 0) ? 2'd2 : 2'd1;
      start = ev_q.size(); x0 = n_exit; l0 = n_lamp;
      press(1'b0, 1'b1, sel, 5);
      wait_quiet(ok);
      model_predict(1'b0, 1'b1, spots, is_full, sel);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL exit_idle[%0d]: busy got 1, required 0", k); end
      n_assert++;
      if (n_exit - x0 != (k == 0 ? 1 : 0)) begin
        n_fail++; $display("FAIL exit_pulses[%0d]: got %0d, required %0d", k, n_exit - x0, (k == 0 ? 1 : 0));
      end
      n_assert++;
      if (n_lamp - l0 != 0) begin n_fail++; $display("FAIL exit_lamp[%0d]: got %0d lamp cycles, required 0", k, n_lamp - l0); end
      n_assert++;
      if (ev_q.size() - start != exp_q.size()) begin
        n_fail++; $display("FAIL exit_ev_count[%0d]: got %0d, required %0d", k, ev_q.size() - start, exp_q.size());
      end else foreach (exp_q[i]) begin
        n_assert++;
        if (ev_q[start + i] != exp_q[i]) begin n_fail++; $display("FAIL exit_ev[%0d][%0d]: got %0d, required %0d", k, i, ev_q[start + i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_tie();
    int start;
    bit ok;
    spots = 4'b0011; is_full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start = ev_q.size();
      model_predict(1'b1, 1'b1, spots, is_full, 2'd0);
      press(1'b1, 1'b1, 2'd0, 5);
      wait_quiet(ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL tie_idle[%0d]: busy got 1, required 0", k); end
      n_assert++;
      if (ev_q.size() - start != exp_q.size()) begin
        n_fail++; $display("FAIL tie_ev_count[%0d]: got %0d, required %0d", k, ev_q.size() - start, exp_q.size());
      end else foreach (exp_q[i]) begin
        n_assert++;
        if (ev_q[start + i] != exp_q[i]) begin n_fail++; $display("FAIL tie_order[%0d][%0d]: got %0d, required %0d", k, i, ev_q[start + i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_ack_timeout();
    int start = ev_q.size(), g0 = n_gate;
    bit ok;
    spots = 4'b0000; is_full = 1'b0;
    ack_en = 1'b0;
    press(1'b1, 1'b0, 2'd0, 3);
    wait_quiet(ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL timeout_idle: busy got 1, required 0"); end
    n_assert++;
    if (last_err_cyc - last_req_cyc != ACK) begin
      n_fail++; $display("FAIL timeout_err_delay: got %0d cycles after request, required %0d", last_err_cyc - last_req_cyc, ACK);
    end
    n_assert++;
    if (n_gate - g0 != 0) begin n_fail++; $display("FAIL timeout_gate: got %0d gate cycles, required 0", n_gate - g0); end
    n_assert++;
    if (ev_q.size() - start != 2 || ev_q[start] != EV_ENTRY || ev_q[start + 1] != EV_ERR) begin
      n_fail++; $display("FAIL timeout_events: got %0d events, required entry request then err", ev_q.size() - start);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_bounce();
    int start = ev_q.size();
    spots = 4'b1111; is_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (k[0]) exit_sensor = 1'b1; else entry_sensor = 1'b1;
      tick(1);
      entry_sensor = 1'b0; exit_sensor = 1'b0;
      tick(2);
    end
    tick(15);
    @(negedge clk);
    n_assert++;
    if (ev_q.size() - start != 0) begin n_fail++; $display("FAIL bounce_no_request: got %0d events, required 0", ev_q.size() - start); end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bounce_busy: got %b, required 0", busy); end
  endtask

  task automatic test_reset_in_open();
    int e0;
    bit found = 1'b0;
    spots = 4'b0000; is_full = 1'b0;
    tick(1);
    entry_sensor = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gate_up) begin found = 1'b1; break; end
    end
    n_assert++;
    if (!found) begin n_fail++; $display("FAIL rst_open_reach: gate_up got 0, required 1 within 40 cycles"); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_assert++;
    if (gate_up !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_open_drop: gate_up=%b busy=%b, required 0 0", gate_up, busy);
    end
    entry_sensor = 1'b0;
    tick(3);
    reset = 1'b1;
`ifdef GATE_RR_ARB_EN
    rr_last_exit = 1'b0;
`endif
    e0 = n_entry;
    tick(20);
    n_assert++;
    if (n_entry - e0 != 0) begin n_fail++; $display("FAIL rst_discard: got %0d entry pulses after reset, required 0", n_entry - e0); end
  endtask

  task automatic test_random();
    int start, g0, acc;
    bit ok, en, ex, full;
    logic [3:0] sp;
    logic [1:0] slot;
    int mode, hold;
    for (int it = 0; it < 25; it++) begin
      mode = $urandom_range(0, 2);
      en   = (mode != 1);
      ex   = (mode != 0);
      sp   = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
      full = ($urandom_range(0, 3) == 0);
      slot = 2'($urandom);
      hold = $urandom_range(4, 9);
      spots = sp; is_full = full;
      start = ev_q.size(); g0 = n_gate;
      model_predict(en, ex, sp, full, slot);
      press(en, ex, slot, hold);
      wait_quiet(ok);
      acc = 0;
      foreach (exp_q[i]) if (exp_q[i] == EV_ENTRY || (exp_q[i] >= EV_EXIT && exp_q[i] < EV_REJ_ENTRY)) acc++;
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL rand_idle[%0d]: busy got 1, required 0", it); end
      n_assert++;
      if (acc == 0 ? (n_gate - g0 != 0) : (n_gate - g0 < OPN * acc)) begin
        n_fail++; $display("FAIL rand_gate[%0d]: got %0d gate cycles for %0d accepted", it, n_gate - g0, acc);
      end
      n_assert++;
      if (ev_q.size() - start != exp_q.size()) begin
        n_fail++; $display("FAIL rand_ev_count[%0d]: got %0d, required %0d (en=%0d ex=%0d spots=%b full=%0d slot=%0d)",
                           it, ev_q.size() - start, exp_q.size(), en, ex, sp, full, slot);
      end else foreach (exp_q[i]) begin
        n_assert++;
        if (ev_q[start + i] != exp_q[i]) begin
          n_fail++; $display("FAIL rand_ev[%0d][%0d]: got %0d, required %0d", it, i, ev_q[start + i], exp_q[i]);
        end
      end
    end
    n_assert++;
    if (n_both != 0) begin n_fail++; $display("FAIL both_requests: got %0d cycles with both pulses, required 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_entry_basic();
    test_full_reject();
    test_exit_slot();
    test_tie();
    test_ack_timeout();
    test_bounce();
    test_reset_in_open();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
